// File: rtl/onehot_encoder_rr_pkg.sv
// Shared types for the round-robin one-hot encoder: default geometry and the
// drain state encoding used to qualify the index stream.
package onehot_encoder_rr_pkg;

    localparam int DEFAULT_IW = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_encoder_rr_if.sv
// Request-vector in / binary-index out handshake bundle. The slave modport is the
// encoder's view; the master modport is the producer/consumer environment.
interface onehot_encoder_rr_if
    import onehot_encoder_rr_pkg::*;
#(
    parameter int IW = DEFAULT_IW
);
    localparam int N = 2 ** IW;

    logic [N-1:0]  req_in;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] idx_out;
    logic          idx_valid;
    logic          idx_ready;
    logic          idx_last;

    modport slave (
        input  req_in, req_valid, idx_ready,
        output req_ready, idx_out, idx_valid, idx_last
    );

    modport master (
        output req_in, req_valid, idx_ready,
        input  req_ready, idx_out, idx_valid, idx_last
    );

endinterface

// File: rtl/onehot_encoder_rr_rr_pick.sv
// Round-robin find-first-set: rotate the vector so ptr sits at bit 0, take the
// lowest set bit, then add ptr back (mod N because N is a power of two).
module rr_pick #(
    parameter int W = 2,
    parameter int N = 2 ** W
) (
    input  logic [N-1:0] pending_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] pick_o,
    output logic         any_o
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W-1:0]   offset;

    assign doubled = {pending_i, pending_i};
    assign rotated = N'(doubled >> ptr_i);

    // Descending scan so the lowest set bit of the rotated view wins.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = W'(i);
            end
        end
    end

    assign pick_o = offset + ptr_i;
    assign any_o  = |pending_i;

endmodule

// File: rtl/onehot_encoder_rr.sv
// Multi-hot request vector to a stream of binary indices, served round-robin from
// a pointer that survives across vectors so no requester is starved.
module onehot_encoder_rr
    import onehot_encoder_rr_pkg::*;
#(
    parameter int input_width  = DEFAULT_IW,
    parameter int output_width = 2 ** input_width
) (
    input  logic                clk,
    input  logic                rst_n,
    onehot_encoder_rr_if.slave  bus
);

    logic [output_width-1:0] pending_q, pending_d;
    logic [input_width-1:0]  ptr_q, ptr_d;
    logic [input_width-1:0]  pick;
    logic                    any;
    logic                    single;
    logic                    fire;
    logic                    accept;
    state_e                  state;

    rr_pick #(
        .W (input_width),
        .N (output_width)
    ) u_pick (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .pick_o    (pick),
        .any_o     (any)
    );

    assign state  = any ? ST_DRAIN : ST_IDLE;
    assign single = ((pending_q & (pending_q - output_width'(1))) == '0);

    assign bus.idx_valid = (state == ST_DRAIN);
    assign bus.idx_out   = (state == ST_DRAIN) ? pick : '0;
    assign bus.idx_last  = (state == ST_DRAIN) && single;

    // Ready early when the last index leaves this cycle, so vectors stream back to back.
    assign bus.req_ready = (state == ST_IDLE) || (bus.idx_last && bus.idx_ready);

    assign fire   = bus.idx_valid && bus.idx_ready;
    assign accept = bus.req_valid && bus.req_ready;

    // A new vector overrides the clear of the final bit fired in the same cycle.
    always_comb begin
        pending_d = pending_q;
        ptr_d     = ptr_q;
        if (fire) begin
            pending_d[pick] = 1'b0;
            ptr_d           = pick + input_width'(1);
        end
        if (accept) begin
            pending_d = bus.req_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_rr.sv
// Directed bench for onehot_encoder_rr (N=4): a per-cycle vector table plus a
// hand-written mid-drain reset sequence.
module tb_onehot_encoder_rr;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    onehot_encoder_rr_if #(.IW(2)) bus ();

    onehot_encoder_rr #(
        .input_width  (2),
        .output_width (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [3:0] rin;
        logic       ir;
        logic       ev;
        logic [1:0] ei;
        logic       el;
        logic       er;
    } vec_t;

    vec_t tbl [21];

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic [1:0] ei, input logic el, input logic er);
        checkOutput({tag, ".idx_valid"}, {3'b0, bus.idx_valid}, {3'b0, ev});
        checkOutput({tag, ".idx_out"},   {2'b0, bus.idx_out},   {2'b0, ei});
        checkOutput({tag, ".idx_last"},  {3'b0, bus.idx_last},  {3'b0, el});
        checkOutput({tag, ".req_ready"}, {3'b0, bus.req_ready}, {3'b0, er});
    endtask

    // Drive one cycle's inputs just after the edge, then check the combinational view.
    task automatic applyStimulus(input string tag, input logic rv, input logic [3:0] rin, input logic ir,
                                 input logic ev, input logic [1:0] ei, input logic el, input logic er);
        @(posedge clk);
        #1;
        bus.req_valid = rv;
        bus.req_in    = rin;
        bus.idx_ready = ir;
        #1;
        checkAll(tag, ev, ei, el, er);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.req_valid = 1'b0;
        bus.req_in    = 4'b0000;
        bus.idx_ready = 1'b0;
        rst_n = 1'b1;

        // 1011 drained at full rate: 0, 1, 3 with last on 3
        tbl[0]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
        // Same vector under 3 cycles of backpressure
        tbl[4]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
        // 0010 accepted on the last fire; ptr moves to 2, then 0011 wraps to 0 first
        tbl[10] = '{1'b1, 4'b0010, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
        // Zero vector leaves ptr at 2, so 0101 starts at 2; then back-to-back 1000
        tbl[15] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 4'b0101, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};

        #2;
        rst_n = 1'b0;
        #1;
        checkAll("reset", 1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        checkAll("post_reset", 1'b0, 2'd0, 1'b0, 1'b1);

        for (int i = 0; i < 21; i++) begin
            applyStimulus($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rin, tbl[i].ir,
                          tbl[i].ev, tbl[i].ei, tbl[i].el, tbl[i].er);
        end

        // Mid-drain reset: 1111 partly consumed, then ptr must restart at 0
        applyStimulus("rst_a", 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus("rst_b", 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus("rst_c", 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        #1;
        bus.idx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAll("rst_async", 1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus("rst_d", 1'b1, 4'b0101, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        applyStimulus("rst_e", 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus("rst_f", 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
        applyStimulus("rst_g", 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
